// File: rtl/mips_pkg.sv
// Shared fetch-path constants and enums for the MIPS core.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_BR   = 2'd1,
    RS_ERET = 2'd2,
    RS_EXC  = 2'd3
  } redir_src_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response and fetch-to-decode handshake bundle.
interface pc_fetch_ctrl_if;

  // im_req/im_gnt: a request transfers in the cycle both are high; im_addr holds
  // while im_req waits. im_rvalid returns the word later, one request in flight.
  // if_valid/id_ready: if_instr/if_pc transfer when both are high and stay
  // stable while if_valid is high and id_ready is low.
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output im_req,
    output im_addr,
    input  im_gnt,
    input  im_rvalid,
    input  im_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_gnt,
    output im_rvalid,
    output im_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// Redirect arbitration: picks the winning redirect source, its target, and
// flags misaligned branch/ERET targets (which fall back to the exception vector).
module pc_next_sel #(
  parameter logic [31:0] EXC_VEC = mips_pkg::EXC_VEC
) (
  input  logic        i_redir_br,
  input  logic [31:0] i_br_target,
  input  logic        i_exc_req,
  input  logic        i_eret_req,
  input  logic [31:0] i_epc,
  output logic        o_redir,
  output logic [31:0] o_target,
  output logic        o_adel
);
  import mips_pkg::*;

  redir_src_t w_src;

  always_comb begin
    w_src = RS_NONE;
    if (i_exc_req)       w_src = RS_EXC;
    else if (i_eret_req) w_src = RS_ERET;
    else if (i_redir_br) w_src = RS_BR;
  end

  always_comb begin
    o_redir  = 1'b0;
    o_target = EXC_VEC;
    o_adel   = 1'b0;
    case (w_src)
      RS_EXC: begin
        o_redir  = 1'b1;
        o_target = EXC_VEC;
      end
      RS_ERET: begin
        o_redir = 1'b1;
        if (is_word_aligned(i_epc)) o_target = i_epc;
        else                        o_adel   = 1'b1;
      end
      RS_BR: begin
        o_redir = 1'b1;
        if (is_word_aligned(i_br_target)) o_target = i_br_target;
        else                              o_adel   = 1'b1;
      end
      default: begin
        o_redir = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: one outstanding instruction-memory request, redirect
// handling with in-flight kill, and a registered valid/ready stage to decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VEC  = mips_pkg::EXC_VEC
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pc_fetch_ctrl_if.master        bus,
  input  logic                   i_redir_br,
  input  logic [31:0]            i_br_target,
  input  logic                   i_exc_req,
  input  logic                   i_eret_req,
  input  logic [31:0]            i_epc,
  output logic                   o_adel,
  output mips_pkg::fetch_state_t o_dbg_state,
  output logic                   o_dbg_kill
);
  import mips_pkg::*;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_kill;
  logic         r_im_req;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic         r_adel;

  logic         w_redir;
  logic [31:0]  w_target;
  logic         w_adel;

  pc_next_sel #(
    .EXC_VEC (EXC_VEC)
  ) u_next_sel (
    .i_redir_br  (i_redir_br),
    .i_br_target (i_br_target),
    .i_exc_req   (i_exc_req),
    .i_eret_req  (i_eret_req),
    .i_epc       (i_epc),
    .o_redir     (w_redir),
    .o_target    (w_target),
    .o_adel      (w_adel)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_im_req   <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
      r_adel     <= 1'b0;
    end else begin
      r_adel <= w_adel;
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_REQ;
          r_im_req <= 1'b1;
          if (w_redir) r_pc <= w_target;
        end
        ST_REQ: begin
          if (w_redir) r_pc <= w_target;
          if (bus.im_gnt) begin
            r_state  <= ST_WAIT;
            r_im_req <= 1'b0;
            // The granted fetch is for the old PC; its data must be discarded.
            if (w_redir) r_kill <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.im_rvalid) begin
            if (w_redir || r_kill) begin
              if (w_redir) r_pc <= w_target;
              r_kill   <= 1'b0;
              r_state  <= ST_REQ;
              r_im_req <= 1'b1;
            end else begin
              r_if_instr <= bus.im_rdata;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              r_pc       <= r_pc + PC_STEP;
              r_state    <= ST_HOLD;
            end
          end else if (w_redir) begin
            r_pc   <= w_target;
            r_kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          // A redirect squashes the held word even if decode is stalled.
          if (w_redir) begin
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
            r_state    <= ST_REQ;
            r_im_req   <= 1'b1;
          end else if (bus.id_ready) begin
            r_if_valid <= 1'b0;
            r_state    <= ST_REQ;
            r_im_req   <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_im_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.im_req   = r_im_req;
  assign bus.im_addr  = r_pc & 32'hFFFF_FFFC;
  assign bus.if_valid = r_if_valid;
  assign bus.if_instr = r_if_instr;
  assign bus.if_pc    = r_if_pc;
  assign o_adel       = r_adel;
  assign o_dbg_state  = r_state;
  assign o_dbg_kill   = r_kill;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch handshake for the MIPS core.
- Holds the architectural fetch PC and selects the next PC from: sequential, branch/jump redirect, exception vector, or ERET return.
- Issues one outstanding request at a time to instruction memory and presents fetched words to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_VEC, 32'h0000_4180, exception entry address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- redir_br  in  1  branch/jump taken (one-cycle pulse).
- br_target  in  32  branch/jump target.
- exc_req  in  1  exception pulse.
- eret_req  in  1  ERET pulse.
- epc  in  32  return address for ERET.
- im_req  out  1  fetch request valid.
- im_addr  out  32  fetch address (word aligned).
- im_gnt  in  1  memory accepted request this cycle.
- im_rvalid  in  1  read data valid.
- im_rdata  in  32  read data.
- if_valid  out  1  instruction to decode valid.
- if_instr  out  32  instruction.
- if_pc  out  32  PC of if_instr.
- id_ready  in  1  decode accepts (low = stall).
- adel  out  1  one-cycle pulse: misaligned redirect target.

Behaviour:
- Reset (rst low, async): state=IDLE, pc=RESET_PC, im_req=0, if_valid=0, if_instr=0, if_pc=0, adel=0, kill=0.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: next cycle goes to REQ. Entered only from reset.
  - REQ: im_req=1, im_addr=pc. On im_gnt go to WAIT. Without im_gnt, im_addr stays stable.
  - WAIT: im_req=0. On im_rvalid, if kill=0: latch im_rdata/pc into if_instr/if_pc, set if_valid=1, pc<=pc+4, go to HOLD. If kill=1: drop the data, clear kill, go to REQ.
  - HOLD: if_valid=1. On id_ready go to REQ and clear if_valid. If id_ready=0, hold all outputs stable.
- Minimum fetch latency: im_gnt in cycle N, im_rvalid in N+1, if_valid in N+2.
- Redirect priority when several pulses coincide: exc_req > eret_req > redir_br.
  - Targets: EXC_VEC, epc, br_target respectively.
- Redirect handling by state:
  - REQ before gnt: pc<=target, im_addr changes next cycle.
  - REQ with gnt in the same cycle: pc<=target, kill<=1, WAIT.
  - WAIT with rvalid in the same cycle: the data is dropped, pc<=target, go to REQ.
  - WAIT without rvalid: pc<=target, kill<=1.
  - HOLD: if_valid<=0, pc<=target, go to REQ (the held instruction is squashed regardless of id_ready).
  - IDLE: pc<=target.
- Misaligned target (bits[1:0]!=0) on redir_br or eret_req:
  - adel=1 for one cycle.
  - pc<=EXC_VEC instead of the target.
  - Ignored for exc_req because EXC_VEC is aligned.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000) with no flag.
- im_addr[1:0] is always 0.
- im_rvalid outside WAIT is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC and EXC_VEC constants.
  - The fetch-state enum (IDLE/REQ/WAIT/HOLD).
  - The redirect-source enum (NONE/BR/ERET/EXC).
- Sub-module pc_next_sel, combinational, contains:
  - The priority encoder over exc/eret/br.
  - The alignment check.
  - The target mux.
  - Outputs: redir, target, adel.
- The FSM and the registers stay in pc_fetch_ctrl.

Test Plan:
- Reset release, im_gnt=1, 1-cycle rvalid, id_ready=1:
  - im_addr 0x3000, 0x3004, 0x3008.
  - if_pc follows with 2-cycle latency.
- id_ready=0 for 5 cycles while in HOLD with if_pc=0x3004:
  - if_valid, if_instr, if_pc stable.
  - No im_req.
  - Resumes at 0x3008.
- redir_br with br_target=0x3100 in WAIT (rvalid arrives next cycle):
  - That word is dropped.
  - Next im_addr=0x3100.
  - Next if_pc=0x3100.
- exc_req, eret_req (epc=0x3040) and redir_br asserted in the same cycle:
  - Next im_addr=0x4180.
- eret_req with epc=0x3042:
  - adel pulses for 1 cycle.
  - Next im_addr=0x4180.
- rst asserted in WAIT, with im_rvalid arriving afterward:
  - Outputs go to reset values immediately.
  - Stale data is ignored.
  - First fetch after release is 0x3000.
